// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl: interrupt controller for a Game Boy style CPU.
// Holds IF (0xFF0F) and IE (0xFFFF), the IME master enable with the delayed
// EI behaviour, and a three-state dispatch FSM (IDLE -> REQUEST -> VECTOR)
// that hands the decoder a request and then overwrites the PC low byte.
// Optional build macro: GB_INT_CANCEL_EN -- when defined the vector is chosen
// from IE&IF at the int_ack cycle, and may resolve to 8'h00 (cancelled
// dispatch, no IF bit cleared). When undefined the vector and IF bit are
// captured on entry to REQUEST.
// Handshake: int_req stays high for the whole REQUEST state; the decoder
// answers with a single-cycle int_ack once the PC push is done; the following
// cycle carries a single-cycle write_interrupt_vector with interrupt_vector.
module gb_cpu_interrupt_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  irq_src,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  bus_wdata,
   input  logic        bus_wren,
   output logic [7:0]  bus_rdata,
   input  logic        instr_boundary,
   input  logic        ei_cmd,
   input  logic        di_cmd,
   input  logic        reti_cmd,
   output logic        int_req,
   input  logic        int_ack,
   output logic        write_interrupt_vector,
   output logic [7:0]  interrupt_vector,
   output logic        int_pending,
   output logic        ime,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_VECTOR  = 2'd2
   } state_t;

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_ie;
   logic [4:0] r_if;
   logic       r_ime;
   logic       r_ei_delay;
   logic [7:0] r_vec;
   logic [4:0] r_clr;
   logic       w_take;
   logic [4:0] w_pend_mask;
   logic [4:0] w_sel;
   logic [4:0] w_if_base;
   logic [4:0] w_if_clr;

   // Map a one-hot interrupt selection to its vector low byte (0 if none).
   function automatic logic [7:0] vec_of(input logic [4:0] oh);
      logic [7:0] v;
      v = 8'h00;
      if (oh[0])      v = 8'h40;
      else if (oh[1]) v = 8'h48;
      else if (oh[2]) v = 8'h50;
      else if (oh[3]) v = 8'h58;
      else if (oh[4]) v = 8'h60;
      return v;
   endfunction

   assign w_pend_mask = r_ie[4:0] & r_if;
   // Isolate the lowest set bit: lowest index has highest priority.
   assign w_sel       = w_pend_mask & (~w_pend_mask + 5'd1);
   assign int_pending = |w_pend_mask;
   assign ime         = r_ime;
   assign o_dbg_state = r_state;

   // Register read mux; unmapped addresses read as zero.
   always_comb begin
      bus_rdata = 8'h00;
      if (bus_addr == ADDR_IF)      bus_rdata = {3'b111, r_if};
      else if (bus_addr == ADDR_IE) bus_rdata = r_ie;
   end

   // Next-state and outputs of the dispatch FSM.
   always_comb begin
      w_next_state           = r_state;
      w_take                 = 1'b0;
      int_req                = 1'b0;
      write_interrupt_vector = 1'b0;
      interrupt_vector       = 8'h00;
      case (r_state)
         ST_IDLE: begin
            // Uses the IME value from before this boundary, so an EI
            // taking effect here still lets the next instruction run.
            if (instr_boundary && r_ime && int_pending) begin
               w_take       = 1'b1;
               w_next_state = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            int_req = 1'b1;
            if (int_ack) w_next_state = ST_VECTOR;
         end
         ST_VECTOR: begin
            write_interrupt_vector = 1'b1;
            interrupt_vector       = r_vec;
            w_next_state           = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // IF: bus write or dispatch clear first, then request pulses on top so
   // a new request is never lost.
   always_comb begin
      w_if_base = (bus_wren && (bus_addr == ADDR_IF)) ? bus_wdata[4:0] : r_if;
      w_if_clr  = (r_state == ST_VECTOR) ? r_clr : 5'h00;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // IE / IF registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ie <= 8'h00;
         r_if <= 5'h01;
      end else begin
         if (bus_wren && (bus_addr == ADDR_IE)) r_ie <= bus_wdata;
         r_if <= (w_if_base & ~w_if_clr) | irq_src;
      end
   end

   // IME and delayed-EI flag; later assignments take precedence (DI last).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ime      <= 1'b0;
         r_ei_delay <= 1'b0;
      end else begin
         if (instr_boundary && r_ei_delay) begin
            r_ime      <= 1'b1;
            r_ei_delay <= 1'b0;
         end
         if (ei_cmd)   r_ei_delay <= 1'b1;
         if (reti_cmd) r_ime      <= 1'b1;
         if (w_take)   r_ime      <= 1'b0;
         if (di_cmd) begin
            r_ime      <= 1'b0;
            r_ei_delay <= 1'b0;
         end
      end
   end

   // Capture the serviced vector and its IF clear mask.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vec <= 8'h00;
         r_clr <= 5'h00;
      end else begin
`ifdef GB_INT_CANCEL_EN
         if ((r_state == ST_REQUEST) && int_ack) begin
            r_vec <= vec_of(w_sel);
            r_clr <= w_sel;
         end
`else
         if (w_take) begin
            r_vec <= vec_of(w_sel);
            r_clr <= w_sel;
         end
`endif
      end
   end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Testbench for gb_cpu_interrupt_ctrl: directed scenarios followed by a
// randomized operation mix, checked against a transaction-level model.
module tb_gb_cpu_interrupt_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  irq_src;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wren;
  logic [7:0]  bus_rdata;
  logic        instr_boundary;
  logic        ei_cmd;
  logic        di_cmd;
  logic        reti_cmd;
  logic        int_req;
  logic        int_ack;
  logic        write_interrupt_vector;
  logic [7:0]  interrupt_vector;
  logic        int_pending;
  logic        ime;
  logic [1:0]  dbg_state;

  gb_cpu_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wren(bus_wren), .bus_rdata(bus_rdata),
    .instr_boundary(instr_boundary), .ei_cmd(ei_cmd), .di_cmd(di_cmd),
    .reti_cmd(reti_cmd), .int_req(int_req), .int_ack(int_ack),
    .write_interrupt_vector(write_interrupt_vector),
    .interrupt_vector(interrupt_vector), .int_pending(int_pending),
    .ime(ime), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // Model of architectural state.
  logic [7:0] m_ie;
  logic [4:0] m_if;
  logic       m_ime;
  logic       m_eid;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every vector write must match the next expected vector.
  always @(negedge clk) begin
    if (reset && write_interrupt_vector) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_vector_write actual=%h required=none", interrupt_vector);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (interrupt_vector !== e) begin
          n_errors++;
          $display("FAIL vector actual=%h required=%h", interrupt_vector, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // All driver tasks start and end right after a falling edge.
  task automatic step();
    @(negedge clk);
    irq_src = 5'h00; bus_wren = 1'b0; instr_boundary = 1'b0;
    ei_cmd = 1'b0; di_cmd = 1'b0; reti_cmd = 1'b0; int_ack = 1'b0;
  endtask

  task automatic model_reset();
    m_ie = 8'h00; m_if = 5'h01; m_ime = 1'b0; m_eid = 1'b0;
  endtask

  function automatic int lowest_idx(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic check_state(input string tag);
    bus_addr = 16'hFF0F; #1;
    chk({tag, "_if"}, {8'h00, bus_rdata}, {8'h00, 3'b111, m_if});
    bus_addr = 16'hFFFF; #1;
    chk({tag, "_ie"}, {8'h00, bus_rdata}, {8'h00, m_ie});
    chk({tag, "_pending"}, {15'h0, int_pending}, {15'h0, |(m_ie[4:0] & m_if)});
    chk({tag, "_ime"}, {15'h0, ime}, {15'h0, m_ime});
  endtask

  task automatic op_irq(input logic [4:0] mask);
    irq_src = mask; step();
    m_if = m_if | mask;
  endtask

  task automatic op_wr(input logic [15:0] a, input logic [7:0] d, input logic [4:0] irq);
    bus_addr = a; bus_wdata = d; bus_wren = 1'b1; irq_src = irq; step();
    if (a == 16'hFF0F) m_if = d[4:0];
    if (a == 16'hFFFF) m_ie = d;
    m_if = m_if | irq;
  endtask

  task automatic op_cmd(input bit ei, input bit di, input bit rt);
    ei_cmd = ei; di_cmd = di; reti_cmd = rt; step();
    if (di) begin
      m_ime = 1'b0; m_eid = 1'b0;
    end else begin
      if (ei) m_eid = 1'b1;
      if (rt) m_ime = 1'b1;
    end
  endtask

  // Instruction boundary; if the model says dispatch, complete the handshake.
  task automatic op_boundary(input int ack_wait, input logic [4:0] irq_vec, output bit disp);
    logic       old_ime;
    logic [4:0] pend;
    int         idx;
    old_ime = m_ime;
    pend    = m_ie[4:0] & m_if;
    if (m_eid) begin
      m_ime = 1'b1; m_eid = 1'b0;
    end
    disp = old_ime && (pend != 5'h00);
    idx  = lowest_idx(pend);
    if (disp) begin
      exp_q.push_back(8'h40 + 8'(idx * 8));
      m_ime = 1'b0;
    end
    instr_boundary = 1'b1; step();
    chk("int_req_after_boundary", {15'h0, int_req}, {15'h0, disp});
    if (disp) begin
      for (int k = 0; k < ack_wait; k++) begin
        step();
        chk("int_req_hold", {15'h0, int_req}, 16'h1);
      end
      int_ack = 1'b1; step();
      chk("int_req_drop", {15'h0, int_req}, 16'h0);
      irq_src = irq_vec; step();
      chk("wiv_one_cycle", {15'h0, write_interrupt_vector}, 16'h0);
      m_if = (m_if & ~(5'(1) << idx)) | irq_vec;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit d;
    reset = 1'b0;
    irq_src = 5'h00; bus_addr = 16'h0000; bus_wdata = 8'h00; bus_wren = 1'b0;
    instr_boundary = 1'b0; ei_cmd = 1'b0; di_cmd = 1'b0; reti_cmd = 1'b0;
    int_ack = 1'b0;
    model_reset();
    @(negedge clk);
    // Reset values, and inputs ignored during reset.
    chk("rst_int_req", {15'h0, int_req}, 16'h0);
    chk("rst_wiv", {15'h0, write_interrupt_vector}, 16'h0);
    chk("rst_vector", {8'h0, interrupt_vector}, 16'h0);
    irq_src = 5'h1F; bus_addr = 16'hFFFF; bus_wdata = 8'hFF; bus_wren = 1'b1;
    reti_cmd = 1'b1; ei_cmd = 1'b1; instr_boundary = 1'b1; step();
    check_state("rst_hold");
    reset = 1'b1; step();
    check_state("rst_release");

    // Basic dispatch of VBlank.
    op_wr(16'hFFFF, 8'h01, 5'h00);
    op_cmd(0, 0, 1);
    op_boundary(0, 5'h00, d);
    chk("basic_dispatched", {15'h0, d}, 16'h1);
    bus_addr = 16'hFF0F; #1; chk("basic_if_E0", {8'h0, bus_rdata}, 16'h00E0);
    check_state("basic");

    // Priority: Timer over Joypad.
    op_wr(16'hFF0F, 8'h14, 5'h00);
    op_wr(16'hFFFF, 8'h1F, 5'h00);
    op_cmd(0, 0, 1);
    op_boundary(2, 5'h00, d);
    bus_addr = 16'hFF0F; #1; chk("prio_if_F0", {8'h0, bus_rdata}, 16'h00F0);

    // EI delay: first boundary does not dispatch, second does.
    op_cmd(1, 0, 0);
    op_boundary(0, 5'h00, d);
    chk("ei_first_boundary", {15'h0, d}, 16'h0);
    op_boundary(1, 5'h00, d);
    chk("ei_second_boundary", {15'h0, d}, 16'h1);

    // Request pulse beats a same-cycle IF write.
    op_wr(16'hFF0F, 8'h00, 5'h04);
    bus_addr = 16'hFF0F; #1; chk("irq_vs_write", {8'h0, bus_rdata}, 16'h00E4);

    // DI wins over EI, and no dispatch on two boundaries.
    op_cmd(0, 0, 1);
    op_cmd(1, 1, 0);
    chk("di_wins_ime", {15'h0, ime}, 16'h0);
    op_boundary(0, 5'h00, d);
    op_boundary(0, 5'h00, d);
    check_state("di_wins");

    // Request in the VECTOR cycle keeps the bit being cleared.
    op_cmd(0, 0, 1);
    op_boundary(1, 5'h04, d);
    bus_addr = 16'hFF0F; #1; chk("irq_vs_clear", {8'h0, bus_rdata}, 16'h00E4);

    // IE cleared while in REQUEST.
    op_wr(16'hFFFF, 8'h04, 5'h00);
    op_cmd(0, 0, 1);
`ifdef GB_INT_CANCEL_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h50);
`endif
    m_ime = 1'b0;
    instr_boundary = 1'b1; step();
    chk("cancel_req", {15'h0, int_req}, 16'h1);
    op_wr(16'hFFFF, 8'h00, 5'h00);
    int_ack = 1'b1; step();
    step();
`ifndef GB_INT_CANCEL_EN
    m_if = m_if & ~5'h04;
`endif
    check_state("cancel");

    // Reset in the middle of a dispatch.
    op_wr(16'hFFFF, 8'h01, 5'h01);
    op_cmd(0, 0, 1);
    instr_boundary = 1'b1; step();
    chk("abort_req_before", {15'h0, int_req}, 16'h1);
    reset = 1'b0; #1;
    model_reset();
    chk("abort_req_cleared", {15'h0, int_req}, 16'h0);
    int_ack = 1'b1; step();
    chk("abort_no_wiv", {15'h0, write_interrupt_vector}, 16'h0);
    reset = 1'b1; step();
    check_state("abort");

    // Randomized operation mix.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: op_irq(5'($urandom_range(0, 31)));
        1: op_wr(16'hFFFF, 8'($urandom_range(0, 255)), 5'h00);
        2: op_wr(16'hFF0F, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'h00);
        3: case ($urandom_range(0, 4))
             0: op_cmd(1, 0, 0);
             1: op_cmd(0, 1, 0);
             2: op_cmd(1, 1, 0);
             default: op_cmd(0, 0, 1);
           endcase
        4, 5, 6: op_boundary(int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'h00, d);
        7: check_state("rand");
        8: begin
          logic [15:0] a;
          a = 16'($urandom_range(0, 65535));
          if (a == 16'hFF0F || a == 16'hFFFF) a = 16'h0000;
          bus_addr = a; #1;
          chk("unmapped_read", {8'h0, bus_rdata}, 16'h0000);
        end
        default: begin
          int_ack = 1'b1; step();
          chk("idle_ack_ignored", {15'h0, int_req}, 16'h0);
        end
      endcase
    end
    check_state("final");
    step();
    chk("leftover_expected", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
